// File: rtl/bus_read_ctrl_pkg.sv
// Shared bus package: read-sequencer state encoding and default bus widths
// (also used by the downstream holding buffer stage).
package bus_read_ctrl_pkg;

  localparam int BUS_DATA_W = 16;
  localparam int BUS_ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WRITE = 2'd2
  } bus_rd_state_e;

endpackage

// File: rtl/bus_read_ctrl.sv
// Single-outstanding bus read sequencer feeding the holding buffer stage.
// Optional ISSUE-phase abort is enabled by defining BUS_READ_TIMEOUT_EN.
module bus_read_ctrl
  import bus_read_ctrl_pkg::*;
#(
  parameter int WIDTH      = BUS_DATA_W,
  parameter int ADDR_WIDTH = BUS_ADDR_W,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic                  cpu_err,
  output logic                  bus_rd,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  bus_ack,
  input  logic [WIDTH-1:0]      bus_rdata,
  output logic                  buf_we,
  output logic [WIDTH-1:0]      buf_din
);

  // Count value on the last ISSUE cycle that may still be waited out.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  bus_rd_state_e         r_state;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [WIDTH-1:0]      r_buf_din;
  logic                  r_cpu_ready;
  logic                  r_bus_rd;
  logic                  r_buf_we;
  logic                  r_cpu_done;
`ifdef BUS_READ_TIMEOUT_EN
  logic [7:0]            r_tmo_cnt;
  logic                  r_cpu_err;
`else
  logic                  w_unused_tmo;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bus_addr  <= '0;
      r_buf_din   <= '0;
      r_cpu_ready <= 1'b1;
      r_bus_rd    <= 1'b0;
      r_buf_we    <= 1'b0;
      r_cpu_done  <= 1'b0;
`ifdef BUS_READ_TIMEOUT_EN
      r_tmo_cnt   <= 8'd0;
      r_cpu_err   <= 1'b0;
`endif
    end else begin
      r_buf_we   <= 1'b0;
      r_cpu_done <= 1'b0;
`ifdef BUS_READ_TIMEOUT_EN
      r_cpu_err  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_bus_addr  <= cpu_addr;
            r_state     <= ST_ISSUE;
            r_cpu_ready <= 1'b0;
            r_bus_rd    <= 1'b1;
`ifdef BUS_READ_TIMEOUT_EN
            r_tmo_cnt   <= 8'd0;
`endif
          end
        end
        ST_ISSUE: begin
          // An ack always beats a simultaneous timeout.
          if (bus_ack) begin
            r_buf_din  <= bus_rdata;
            r_state    <= ST_WRITE;
            r_bus_rd   <= 1'b0;
            r_buf_we   <= 1'b1;
            r_cpu_done <= 1'b1;
          end
`ifdef BUS_READ_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_state     <= ST_IDLE;
            r_bus_rd    <= 1'b0;
            r_cpu_ready <= 1'b1;
            r_cpu_err   <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
`endif
        end
        ST_WRITE: begin
          r_state     <= ST_IDLE;
          r_cpu_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cpu_ready <= 1'b1;
          r_bus_rd    <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_READ_TIMEOUT_EN
  assign cpu_err = r_cpu_err;
`else
  assign cpu_err      = 1'b0;
  assign w_unused_tmo = ^TMO_LAST;
`endif

  assign cpu_ready = r_cpu_ready;
  assign cpu_done  = r_cpu_done;
  assign bus_rd    = r_bus_rd;
  assign bus_addr  = r_bus_addr;
  assign buf_we    = r_buf_we;
  assign buf_din   = r_buf_din;

endmodule
